pu_issue: RTL and testbench

- Decode/issue stage directly upstream of the processing-unit (PU) chain (add/sub/compare and sibling units).
- Accepts 32-bit instruction words from fetch over a valid/ready handshake and splits them into opcode, register-number and compare-op fields.
- Presents those fields to the PU chain and watches the chain's acknowledge and busy signals to retire, stall or trap.
- Holds the architectural compare flag, which it latches from the PU's flag write port.

---
 rtl/pu_issue.sv | 170 +++++++++++++++++
 tb/tb_pu_issue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pu_issue.sv
// pu_issue: decode/issue stage feeding the processing-unit chain.
// Splits fetched words into fields, issues them, and then retires, stalls
// or traps depending on the chain's ack/busy. It also holds the compare flag.
// Optional macro PU_ISSUE_PERF_CNT_EN adds retire and stall-cycle counters.
module pu_issue #(
  parameter int OPTION_OPCODE_WIDTH = 6,
  parameter logic [OPTION_OPCODE_WIDTH-1:0] OPTION_NOP_OPCODE = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_instr_valid,
  input  logic [31:0]                    i_instr,
  output logic                           o_instr_ready,
  output logic                           o_issue_valid,
  output logic [OPTION_OPCODE_WIDTH-1:0] o_opcode,
  output logic [4:0]                     o_rega,
  output logic [4:0]                     o_regb,
  output logic [4:0]                     o_regd,
  output logic [3:0]                     o_cmp_op,
  input  logic                           i_chain_ack,
  input  logic                           i_pu_busy,
  input  logic                           i_write_flag,
  input  logic                           i_flag_cmp,
  output logic                           o_flag,
  output logic                           o_trap,
  output logic [OPTION_OPCODE_WIDTH-1:0] o_trap_opcode,
  input  logic                           i_trap_clr
`ifdef PU_ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]                    o_retired_cnt,
  output logic [31:0]                    o_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, STALL, TRAP} state_t;

  state_t                         state_q, state_d;
  logic [OPTION_OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [4:0]                     rega_q, rega_d;
  logic [4:0]                     regb_q, regb_d;
  logic [4:0]                     regd_q, regd_d;
  logic [3:0]                     cmp_op_q, cmp_op_d;
  logic                           flag_q, flag_d;
  logic                           retire;
  logic                           load;
  logic                           issue_valid;
  logic                           ready;

  // Bits [10:4] of the instruction word carry no meaning for this stage.
  logic unused_instr_bits;
  assign unused_instr_bits = ^i_instr[10:4];

  // Next-state, field capture, flag update and handshake decisions.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    rega_d      = rega_q;
    regb_d      = regb_q;
    regd_d      = regd_q;
    cmp_op_d    = cmp_op_q;
    flag_d      = flag_q;
    retire      = 1'b0;
    load        = 1'b0;
    issue_valid = 1'b0;
    ready       = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (i_instr_valid) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (i_chain_ack && !i_pu_busy) retire = 1'b1;
        else if (i_chain_ack)          state_d = STALL;
        else                           state_d = TRAP;
      end
      STALL: begin
        issue_valid = 1'b1;
        if (!i_pu_busy)         retire = 1'b1;
        else if (!i_chain_ack)  state_d = TRAP;
      end
      TRAP: begin
        if (i_trap_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (retire) begin
      ready = 1'b1;
      if (i_write_flag) flag_d = i_flag_cmp;
      if (i_instr_valid) begin
        load    = 1'b1;
        state_d = ISSUE;
      end else begin
        state_d = IDLE;
      end
    end
    if (load) begin
      opcode_d = i_instr[31:32-OPTION_OPCODE_WIDTH];
      regd_d   = i_instr[25:21];
      rega_d   = i_instr[20:16];
      regb_d   = i_instr[15:11];
      cmp_op_d = i_instr[3:0];
    end
    if (!i_rst) ready = 1'b0;
  end

  // State, latched fields and compare flag, cleared by synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      opcode_q <= OPTION_NOP_OPCODE;
      rega_q   <= '0;
      regb_q   <= '0;
      regd_q   <= '0;
      cmp_op_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      rega_q   <= rega_d;
      regb_q   <= regb_d;
      regd_q   <= regd_d;
      cmp_op_q <= cmp_op_d;
      flag_q   <= flag_d;
    end
  end

  // Drive fields only while issuing so idle/trap cycles present a NOP.
  always_comb begin
    o_instr_ready = ready;
    o_issue_valid = issue_valid;
    o_opcode      = issue_valid ? opcode_q : OPTION_NOP_OPCODE;
    o_rega        = issue_valid ? rega_q   : 5'd0;
    o_regb        = issue_valid ? regb_q   : 5'd0;
    o_regd        = issue_valid ? regd_q   : 5'd0;
    o_cmp_op      = issue_valid ? cmp_op_q : 4'd0;
    o_flag        = flag_q;
    o_trap        = (state_q == TRAP);
    o_trap_opcode = (state_q == TRAP) ? opcode_q : '0;
  end

`ifdef PU_ISSUE_PERF_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running, wrapping counters of retires and cycles spent stalled.
  always_comb begin
    retired_cnt_d = retired_cnt_q + {31'd0, retire};
    stall_cnt_d   = stall_cnt_q + {31'd0, (state_q == STALL)};
  end

  // Counter registers, cleared by synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign o_retired_cnt = retired_cnt_q;
  assign o_stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pu_issue.sv
// Testbench for pu_issue: directed vector table, a hand-written trap/reset
// sequence, and randomized traffic checked against a behavioural model.
module tb_pu_issue;

  logic        i_clk = 1'b0;
  logic        i_rst, i_instr_valid, i_chain_ack, i_pu_busy;
  logic        i_write_flag, i_flag_cmp, i_trap_clr;
  logic [31:0] i_instr;
  logic        o_instr_ready, o_issue_valid, o_flag, o_trap;
  logic [5:0]  o_opcode, o_trap_opcode;
  logic [4:0]  o_rega, o_regb, o_regd;
  logic [3:0]  o_cmp_op;
`ifdef PU_ISSUE_PERF_CNT_EN
  logic [31:0] o_retired_cnt, o_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  pu_issue dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_instr_valid(i_instr_valid), .i_instr(i_instr),
    .o_instr_ready(o_instr_ready), .o_issue_valid(o_issue_valid),
    .o_opcode(o_opcode), .o_rega(o_rega), .o_regb(o_regb),
    .o_regd(o_regd), .o_cmp_op(o_cmp_op),
    .i_chain_ack(i_chain_ack), .i_pu_busy(i_pu_busy),
    .i_write_flag(i_write_flag), .i_flag_cmp(i_flag_cmp),
    .o_flag(o_flag), .o_trap(o_trap), .o_trap_opcode(o_trap_opcode),
    .i_trap_clr(i_trap_clr)
`ifdef PU_ISSUE_PERF_CNT_EN
    , .o_retired_cnt(o_retired_cnt), .o_stall_cnt(o_stall_cnt)
`endif
  );

  // 10 ns clock.
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst, valid;
    logic [31:0] instr;
    logic        ack, busy, wf, fc, clr;
    logic        e_ready, e_ivalid;
    logic [24:0] e_fields;
    logic        e_flag, e_trap;
    logic [5:0]  e_topc;
  } vec_t;

  vec_t tbl[30];

  localparam logic [31:0] ADD  = 32'h0822_1800;
  localparam logic [31:0] ICMP = 32'h0C22_180A;
  localparam logic [31:0] BAD  = 32'hFC00_0000;

  function automatic logic [24:0] fld(input int opc, input int d, input int a,
                                      input int b, input int c);
    fld = {opc[5:0], d[4:0], a[4:0], b[4:0], c[3:0]};
  endfunction

  function automatic vec_t mk(input logic rst, input logic valid, input logic [31:0] instr,
                              input logic ack, input logic busy, input logic wf,
                              input logic fc, input logic clr, input logic e_ready,
                              input logic e_ivalid, input logic [24:0] e_fields,
                              input logic e_flag, input logic e_trap, input logic [5:0] e_topc);
    vec_t v;
    v.rst = rst; v.valid = valid; v.instr = instr; v.ack = ack; v.busy = busy;
    v.wf = wf; v.fc = fc; v.clr = clr; v.e_ready = e_ready; v.e_ivalid = e_ivalid;
    v.e_fields = e_fields; v.e_flag = e_flag; v.e_trap = e_trap; v.e_topc = e_topc;
    mk = v;
  endfunction

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [31:0] instr,
                               input logic ack, input logic busy, input logic wf,
                               input logic fc, input logic clr);
    @(negedge i_clk);
    i_rst = rst; i_instr_valid = valid; i_instr = instr; i_chain_ack = ack;
    i_pu_busy = busy; i_write_flag = wf; i_flag_cmp = fc; i_trap_clr = clr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic e_ready, input logic e_ivalid,
                          input logic [24:0] e_fields, input logic e_flag,
                          input logic e_trap, input logic [5:0] e_topc);
    checkOutput({tag, " ready"}, {31'd0, o_instr_ready}, {31'd0, e_ready});
    checkOutput({tag, " issue_valid"}, {31'd0, o_issue_valid}, {31'd0, e_ivalid});
    checkOutput({tag, " fields"}, {7'd0, o_opcode, o_regd, o_rega, o_regb, o_cmp_op},
                {7'd0, e_fields});
    checkOutput({tag, " flag"}, {31'd0, o_flag}, {31'd0, e_flag});
    checkOutput({tag, " trap"}, {31'd0, o_trap}, {31'd0, e_trap});
    checkOutput({tag, " trap_opcode"}, {26'd0, o_trap_opcode}, {26'd0, e_topc});
  endtask

  // Behavioural model: an instruction is either absent, in flight (first
  // cycle or already stalled), or parked as a trap.
  logic        m_holding, m_stalled, m_trapped, m_flag;
  logic [31:0] m_word;
  int unsigned m_retired, m_stalls;

  function automatic logic [24:0] decode(input logic [31:0] w);
    decode = {w[31:26], w[25:21], w[20:16], w[15:11], w[3:0]};
  endfunction

  initial begin
    logic rst, valid, ack, busy, wf, fc, clr;
    logic [31:0] instr;
    logic retire, trapnow;

    // Directed table: inputs for a cycle and the outputs expected in it.
    tbl[0]  = mk(0,0,0,   0,0,0,0,0, 0,0,0,0,0,0);
    tbl[1]  = mk(1,1,ADD, 0,0,0,0,0, 1,0,0,0,0,0);
    tbl[2]  = mk(1,0,0,   1,0,0,0,0, 1,1,fld(2,1,2,3,0),0,0,0);
    tbl[3]  = mk(1,1,ICMP,0,0,0,0,0, 1,0,0,0,0,0);
    tbl[4]  = mk(1,0,0,   1,0,1,1,0, 1,1,fld(3,1,2,3,10),0,0,0);
    tbl[5]  = mk(1,1,ADD, 0,0,0,0,0, 1,0,0,1,0,0);
    tbl[6]  = mk(1,0,0,   1,0,0,0,0, 1,1,fld(2,1,2,3,0),1,0,0);
    tbl[7]  = mk(1,0,0,   0,0,0,0,0, 1,0,0,1,0,0);
    tbl[8]  = mk(1,1,ADD, 0,0,0,0,0, 1,0,0,1,0,0);
    tbl[9]  = mk(1,0,0,   1,1,0,0,0, 0,1,fld(2,1,2,3,0),1,0,0);
    tbl[10] = mk(1,0,0,   1,1,1,0,0, 0,1,fld(2,1,2,3,0),1,0,0);
    tbl[11] = mk(1,0,0,   1,1,0,0,0, 0,1,fld(2,1,2,3,0),1,0,0);
    tbl[12] = mk(1,0,0,   1,0,0,0,0, 1,1,fld(2,1,2,3,0),1,0,0);
    tbl[13] = mk(1,0,0,   0,0,0,0,0, 1,0,0,1,0,0);
    tbl[14] = mk(1,1,BAD, 0,0,0,0,0, 1,0,0,1,0,0);
    tbl[15] = mk(1,0,0,   0,0,0,0,0, 0,1,fld(63,0,0,0,0),1,0,0);
    tbl[16] = mk(1,1,ADD, 0,0,0,0,0, 0,0,0,1,1,6'h3F);
    tbl[17] = mk(1,1,ADD, 0,0,0,0,1, 0,0,0,1,1,6'h3F);
    tbl[18] = mk(1,0,0,   0,0,0,0,0, 1,0,0,1,0,0);
    tbl[19] = mk(1,1,ADD|32'd0, 0,0,0,0,0, 1,0,0,1,0,0);
    tbl[20] = mk(1,1,ADD|32'd1, 1,0,0,0,0, 1,1,fld(2,1,2,3,0),1,0,0);
    tbl[21] = mk(1,1,ADD|32'd2, 1,0,0,0,0, 1,1,fld(2,1,2,3,1),1,0,0);
    tbl[22] = mk(1,1,ADD|32'd3, 1,0,0,0,0, 1,1,fld(2,1,2,3,2),1,0,0);
    tbl[23] = mk(1,0,0,   1,0,0,0,0, 1,1,fld(2,1,2,3,3),1,0,0);
    tbl[24] = mk(1,0,0,   0,0,0,0,0, 1,0,0,1,0,0);
    tbl[25] = mk(1,1,ADD, 0,0,0,0,0, 1,0,0,1,0,0);
    tbl[26] = mk(1,0,0,   1,1,0,0,0, 0,1,fld(2,1,2,3,0),1,0,0);
    tbl[27] = mk(0,0,0,   1,1,0,0,0, 0,1,fld(2,1,2,3,0),1,0,0);
    tbl[28] = mk(0,1,ADD, 1,1,0,0,0, 0,0,0,0,0,0);
    tbl[29] = mk(1,0,0,   0,0,0,0,0, 1,0,0,0,0,0);

    // Bring the design out of its unknown power-up state.
    applyStimulus(0,0,0,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0,0);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].valid, tbl[i].instr, tbl[i].ack,
                    tbl[i].busy, tbl[i].wf, tbl[i].fc, tbl[i].clr);
      checkAll($sformatf("row%0d", i), tbl[i].e_ready, tbl[i].e_ivalid,
               tbl[i].e_fields, tbl[i].e_flag, tbl[i].e_trap, tbl[i].e_topc);
`ifdef PU_ISSUE_PERF_CNT_EN
      if (i == 13) begin
        checkOutput("row13 stall_cnt", o_stall_cnt, 32'd3);
        checkOutput("row13 retired_cnt", o_retired_cnt, 32'd4);
      end
`endif
    end

    // Hand-written: reset while a trap is pending clears the trap.
    applyStimulus(1,1,BAD,0,0,0,0,0);
    checkAll("hs accept", 1, 0, 0, 0, 0, 0);
    applyStimulus(1,0,0,  0,0,0,0,0);
    checkAll("hs issue", 0, 1, fld(63,0,0,0,0), 0, 0, 0);
    applyStimulus(1,0,0,  0,0,0,0,0);
    checkAll("hs trapped", 0, 0, 0, 0, 1, 6'h3F);
    applyStimulus(0,0,0,  0,0,0,0,0);
    checkAll("hs rst pre", 0, 0, 0, 0, 1, 6'h3F);
    applyStimulus(0,0,0,  0,0,0,0,0);
    checkAll("hs rst post", 0, 0, 0, 0, 0, 0);
    applyStimulus(1,0,0,  0,0,0,0,0);
    checkAll("hs idle", 1, 0, 0, 0, 0, 0);

    // Randomized traffic against the model; the design is idle and clean here.
    m_holding = 0; m_stalled = 0; m_trapped = 0; m_flag = 0; m_word = '0;
    m_retired = 0; m_stalls = 0;
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 63) != 0);
      valid = $urandom_range(0, 1);
      instr = $urandom;
      ack   = ($urandom_range(0, 7) != 0);
      busy  = ($urandom_range(0, 2) == 0);
      wf    = $urandom_range(0, 1);
      fc    = $urandom_range(0, 1);
      clr   = ($urandom_range(0, 3) == 0);
      applyStimulus(rst, valid, instr, ack, busy, wf, fc, clr);

      retire  = m_holding && !busy && (m_stalled || ack);
      trapnow = m_holding && !ack && (!m_stalled || busy);
      checkAll($sformatf("rnd%0d", c),
               rst && ((!m_holding && !m_trapped) || retire),
               m_holding, m_holding ? decode(m_word) : 25'd0,
               m_flag, m_trapped, m_trapped ? m_word[31:26] : 6'd0);
`ifdef PU_ISSUE_PERF_CNT_EN
      checkOutput($sformatf("rnd%0d retired_cnt", c), o_retired_cnt, m_retired);
      checkOutput($sformatf("rnd%0d stall_cnt", c), o_stall_cnt, m_stalls);
`endif

      @(posedge i_clk);
      if (!rst) begin
        m_holding = 0; m_stalled = 0; m_trapped = 0; m_flag = 0;
        m_retired = 0; m_stalls = 0;
      end else begin
        if (m_holding && m_stalled) m_stalls++;
        if (m_trapped) begin
          if (clr) m_trapped = 0;
        end else if (m_holding) begin
          if (retire) begin
            m_retired++;
            if (wf) m_flag = fc;
            m_holding = valid;
            m_stalled = 0;
            if (valid) m_word = instr;
          end else if (trapnow) begin
            m_holding = 0;
            m_stalled = 0;
            m_trapped = 1;
          end else begin
            m_stalled = 1;
          end
        end else if (valid) begin
          m_holding = 1;
          m_stalled = 0;
          m_word = instr;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
